// File: rtl/hierIncludeCInclude_package.sv
// Shared types and constants for the d-stream burst sender.
package hierIncludeCInclude_package;

  localparam int D_SIZE         = 3;
  localparam int C_ANOTHER_SIZE = 10;
  localparam int LEN_W          = 4;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(C_ANOTHER_SIZE);

  typedef logic [D_SIZE-1:0] dT;

  typedef struct packed {
    dT d;
  } dSt;

  typedef enum logic [3:0] {
    IDLE = 4'h0,
    SEND = 4'h1,
    DONE = 4'h2,
    ERR  = 4'h3
  } cStateT;

  localparam cStateT RESET_STATE = IDLE;

endpackage

// File: rtl/d_stream_sender.sv
// Burst sender: a request of (seed, len) produces len incrementing items
// on a valid/ready stream, followed by a one-cycle done (or err) pulse.
module d_stream_sender
  import hierIncludeCInclude_package::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_vld,
  output logic       start_rdy,
  input  dT          start_seed,
  input  logic [3:0] start_len,
  output logic       d_vld,
  input  logic       d_rdy,
  output dSt         d_data,
  output logic       d_last,
  output logic       done,
  output logic       err,
  output cStateT     state_o
);

  cStateT           state, next_state;
  logic [LEN_W-1:0] cnt, next_cnt;
  dT                data, next_data;
  logic             len_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
      cnt   <= '0;
      data  <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      data  <= next_data;
    end
  end

  assign len_ok = (start_len != '0) && (start_len <= MAX_LEN);

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_data  = data;
    start_rdy  = 1'b0;
    d_vld      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    case (state)
      IDLE: begin
        start_rdy = 1'b1;
        if (start_vld) begin
          if (len_ok) begin
            next_state = SEND;
            next_cnt   = start_len;
            next_data  = start_seed;
          end else begin
            next_state = ERR;
          end
        end
      end
      SEND: begin
        // A zero count here can only come from corruption; bail out rather than underflow.
        if (cnt == '0) begin
          next_state = IDLE;
        end else begin
          d_vld = 1'b1;
          if (d_rdy) begin
            next_data = data + dT'(1);
            next_cnt  = cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              next_state = DONE;
            end
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      ERR: begin
        err        = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign d_last   = d_vld && (cnt == LEN_W'(1));
  assign d_data   = '{d: data};
  assign state_o  = state;

endmodule

// File: doc/d_stream_sender.md
D_STREAM_SENDER -- requirements
Module: d_stream_sender

Interface
REQ-001 Parameter D_SIZE, 3, width of dT payload (package constant, not overridable per instance).
REQ-002 Parameter C_ANOTHER_SIZE, 10, maximum burst length in items (package constant).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start_vld  input  1  burst request valid.
REQ-006 start_rdy  output  1  burst request accepted when start_vld && start_rdy.
REQ-007 start_seed  input  dT  first payload value of burst.
REQ-008 start_len  input  4  items in burst; legal range 1..C_ANOTHER_SIZE.
REQ-009 d_vld  output  1  dSt item valid.
REQ-010 d_rdy  input  1  downstream receiver accepts item when d_vld && d_rdy.
REQ-011 d_data  output  dSt  item payload (field d).
REQ-012 d_last  output  1  marks final item of burst; qualified by d_vld.
REQ-013 done  output  1  one-cycle pulse after final item accepted.
REQ-014 err  output  1  one-cycle pulse on rejected illegal request.
REQ-015 state_o  output  cStateT  current FSM state for debug.

Function
REQ-016 States (cStateT encoding): IDLE=4'h0, SEND=4'h1, DONE=4'h2, ERR=4'h3; other codes SHALL return to IDLE next cycle.
REQ-017 start_rdy SHALL be 1 only in IDLE; request accepted in IDLE moves to SEND (legal len) or ERR (len==0 or len>C_ANOTHER_SIZE).
REQ-018 SEND: d_vld=1; first item presented the cycle after acceptance (1-cycle latency); d_data.d = seed for item 0.
REQ-019 Each accepted item: d_data.d increments by 1 modulo 2^D_SIZE (7 wraps to 0); remaining count decrements.
REQ-020 d_data, d_last SHALL hold stable while d_vld && !d_rdy; d_vld never drops before acceptance.
REQ-021 d_last=1 exactly when remaining count==1; acceptance of that item moves SEND->DONE.
REQ-022 DONE: done=1 for one cycle, then IDLE; start_rdy=0 in DONE (no back-to-back acceptance in the same cycle).
REQ-023 ERR: err=1 for one cycle, no items emitted, then IDLE.
REQ-024 start_vld without start_rdy SHALL be ignored; inputs sampled only on acceptance.
REQ-025 Remaining counter width 4 bits; never underflows; len==C_ANOTHER_SIZE yields exactly 10 items.
REQ-026 d_rdy asserted without d_vld SHALL have no effect.

Reset
REQ-027 rst=1 at a clock edge: state IDLE, d_vld=0, d_last=0, d_data=0, done=0, err=0, counter=0; start_rdy=1 the cycle after rst deasserts.
REQ-028 rst mid-burst SHALL abandon burst; no done pulse; next burst starts clean.

Structure
REQ-029 cStateT, dT, dSt, D_SIZE, C_ANOTHER_SIZE SHALL come from shared package hierIncludeCInclude_package; state localparams added there.
REQ-030 Single flat module; no sub-module.

Verification
REQ-031 seed=5, len=4, d_rdy=1 -> d = 5,6,7,0 on consecutive cycles, d_last on 4th, done next cycle.
REQ-032 seed=0, len=3, d_rdy toggling 1,0,0,1,1 -> values 0,1,2 held stable during stalls, exactly 3 accepted.
REQ-033 len=0 then len=11 -> err pulse each, d_vld never asserted, start_rdy back in IDLE.
REQ-034 len=10, seed=2 -> 10 items 2..7,0..3, d_last only on 10th.
REQ-035 rst asserted after 2 of 6 items -> all outputs 0 next cycle, no done; new len=1 burst completes normally.
REQ-036 start_vld held high through burst -> second request accepted only after DONE returns to IDLE.
